// File: rtl/dc_token_ring_ptr_hyper_if.sv
// Pointer-side bundle of the token-ring pointer: control in, ring view out.
// The master drives enable/clear; the slave (the pointer) returns its state.
interface dc_token_ring_ptr_hyper_if #(
   parameter int BUFFER_DEPTH = 8,
   parameter int IDX_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1
);
   logic                    enable;
   logic                    clear;
   logic [BUFFER_DEPTH-1:0] state;
   logic [IDX_W-1:0]        head_idx;
   logic                    lap;
   logic                    err;

   modport master (
      output enable, clear,
      input  state, head_idx, lap, err
   );

   modport slave (
      input  enable, clear,
      output state, head_idx, lap, err
   );
endinterface

// File: rtl/dc_token_ring_ptr_hyper.sv
// Token-ring pointer for hyperbus dual-clock FIFOs: rotating run of ones,
// shadow head index, lap bit, sticky integrity error and optional self-repair.
module dc_token_ring_ptr_hyper #(
   parameter int BUFFER_DEPTH = 8,
   parameter int TOKEN_WIDTH  = 2,
   parameter int REPAIR       = 1
) (
   input  logic clk,
   input  logic rstn,
   dc_token_ring_ptr_hyper_if.slave ptr_io
);
   localparam int D     = BUFFER_DEPTH;
   localparam int T     = TOKEN_WIDTH;
   localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
   localparam bit FIX   = (REPAIR != 0);

   if (D < 2 || T < 1 || T >= D) begin : g_bad_param
      $error("dc_token_ring_ptr_hyper: illegal BUFFER_DEPTH/TOKEN_WIDTH");
   end

   // Bit i belongs to the run when it lies 0..T-1 places behind head h.
   function automatic logic [D-1:0] exp_pat(input logic [IDX_W-1:0] h);
      logic [D-1:0] p;
      p = '0;
      for (int i = 0; i < D; i++) begin
         p[i] = ((int'(h) - i + D) % D) < T;
      end
      return p;
   endfunction

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(D - 1);
   localparam logic [IDX_W-1:0] IDX_RST = IDX_W'(T - 1);
   localparam logic [D-1:0]     ST_RST  = exp_pat(IDX_RST);

   logic [D-1:0]     state_q, state_d;
   logic [IDX_W-1:0] head_q, head_d;
   logic             lap_q, lap_d;
   logic             err_q, err_d;

   logic [D-1:0]     exp_w;
   logic [D-1:0]     base_w;
   logic             mism_w;

   always_comb begin
      exp_w   = exp_pat(head_q);
      mism_w  = (state_q != exp_w);
      base_w  = (FIX && mism_w) ? exp_w : state_q;
      state_d = base_w;
      head_d  = head_q;
      lap_d   = lap_q;
      err_d   = err_q | mism_w;
      if (ptr_io.clear) begin
         state_d = ST_RST;
         head_d  = IDX_RST;
         lap_d   = 1'b0;
         err_d   = 1'b0;
      end else if (ptr_io.enable) begin
         state_d = {base_w[D-2:0], base_w[D-1]};
         if (head_q == IDX_MAX) begin
            head_d = '0;
            lap_d  = ~lap_q;
         end else begin
            head_d = head_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_RST;
         head_q  <= IDX_RST;
         lap_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         lap_q   <= lap_d;
         err_q   <= err_d;
      end
   end

   assign ptr_io.state    = state_q;
   assign ptr_io.head_idx = head_q;
   assign ptr_io.lap      = lap_q;
   assign ptr_io.err      = err_q;
endmodule

// File: tb/tb_dc_token_ring_ptr_hyper.sv
// Scoreboard bench for the token-ring pointer: four configurations share
// enable/clear; a queue of predicted snapshots is drained by a monitor.
module tb_dc_token_ring_ptr_hyper;
   typedef struct packed {
      logic [7:0] s;
      logic [3:0] h;
      logic       lap;
      logic       err;
   } snap_t;
   typedef snap_t [3:0] snap4_t;

   logic clk = 1'b0;
   logic rstn;
   logic en;
   logic clr;
   logic [7:0] inj_v;

   int errors = 0;
   int checks = 0;
   snap4_t sb[$];

   int md[4] = '{8, 8, 2, 5};
   int mt[4] = '{2, 2, 1, 4};
   bit mr[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0] ms[4];
   int mh[4];
   bit ml[4];
   bit me[4];

   always #5 clk = ~clk;

   dc_token_ring_ptr_hyper_if #(.BUFFER_DEPTH(8)) i0 ();
   dc_token_ring_ptr_hyper_if #(.BUFFER_DEPTH(8)) i1 ();
   dc_token_ring_ptr_hyper_if #(.BUFFER_DEPTH(2)) i2 ();
   dc_token_ring_ptr_hyper_if #(.BUFFER_DEPTH(5)) i3 ();

   assign i0.enable = en;
   assign i0.clear  = clr;
   assign i1.enable = en;
   assign i1.clear  = clr;
   assign i2.enable = en;
   assign i2.clear  = clr;
   assign i3.enable = en;
   assign i3.clear  = clr;

   dc_token_ring_ptr_hyper #(
      .BUFFER_DEPTH(8), .TOKEN_WIDTH(2), .REPAIR(1)
   ) dut0 (.clk(clk), .rstn(rstn), .ptr_io(i0));

   dc_token_ring_ptr_hyper #(
      .BUFFER_DEPTH(8), .TOKEN_WIDTH(2), .REPAIR(0)
   ) dut1 (.clk(clk), .rstn(rstn), .ptr_io(i1));

   dc_token_ring_ptr_hyper #(
      .BUFFER_DEPTH(2), .TOKEN_WIDTH(1), .REPAIR(1)
   ) dut2 (.clk(clk), .rstn(rstn), .ptr_io(i2));

   dc_token_ring_ptr_hyper #(
      .BUFFER_DEPTH(5), .TOKEN_WIDTH(4), .REPAIR(1)
   ) dut3 (.clk(clk), .rstn(rstn), .ptr_io(i3));

   // Token positions are head, head-1, .. head-t+1 around a ring of d.
   function automatic logic [7:0] m_exp(int d, int t, int h);
      logic [7:0] p;
      p = '0;
      for (int j = 0; j < t; j++) begin
         p = p | (8'(1) << ((h - j + d) % d));
      end
      return p;
   endfunction

   // Every occupied position moves one place forward around the ring.
   function automatic logic [7:0] m_rot(int d, logic [7:0] s);
      logic [7:0] o;
      o = '0;
      for (int i = 0; i < d; i++) begin
         if (((s >> i) & 8'(1)) != 0) o = o | (8'(1) << ((i + 1) % d));
      end
      return o;
   endfunction

   function automatic void m_reset(int k);
      ms[k] = m_exp(md[k], mt[k], mt[k] - 1);
      mh[k] = mt[k] - 1;
      ml[k] = 1'b0;
      me[k] = 1'b0;
   endfunction

   function automatic void m_step(int k, bit e, bit c);
      logic [7:0] x;
      bit bad;
      if (c) begin
         m_reset(k);
         return;
      end
      x = m_exp(md[k], mt[k], mh[k]);
      bad = (ms[k] != x);
      me[k] = me[k] | bad;
      if (!(mr[k] && bad)) x = ms[k];
      ms[k] = e ? m_rot(md[k], x) : x;
      if (e) begin
         mh[k] = (mh[k] + 1) % md[k];
         if (mh[k] == 0) ml[k] = !ml[k];
      end
   endfunction

   function automatic snap4_t mk_exp();
      snap4_t a;
      for (int k = 0; k < 4; k++) begin
         a[k] = '{s: ms[k], h: 4'(mh[k]), lap: ml[k], err: me[k]};
      end
      return a;
   endfunction

   function automatic snap4_t act();
      snap4_t a;
      a[0] = '{s: i0.state, h: 4'(i0.head_idx),
               lap: i0.lap, err: i0.err};
      a[1] = '{s: i1.state, h: 4'(i1.head_idx),
               lap: i1.lap, err: i1.err};
      a[2] = '{s: 8'(i2.state), h: 4'(i2.head_idx),
               lap: i2.lap, err: i2.err};
      a[3] = '{s: 8'(i3.state), h: 4'(i3.head_idx),
               lap: i3.lap, err: i3.err};
      return a;
   endfunction

   function automatic void chk(int k, string nm, snap_t a, snap_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s inst%0d @%0t: got s=%h h=%0d lap=%b err=%b, want s=%h h=%0d lap=%b err=%b",
                  nm, k, $time, a.s, a.h, a.lap, a.err,
                  e.s, e.h, e.lap, e.err);
      end
   endfunction

   function automatic void step_all(bit e, bit c);
      for (int k = 0; k < 4; k++) m_step(k, e, c);
      sb.push_back(mk_exp());
   endfunction

   task automatic cyc(bit e, bit c);
      @(negedge clk);
      rstn = 1'b1;
      en = e;
      clr = c;
      step_all(e, c);
   endtask

   // Corrupt both depth-8 rings for the coming edge.
   task automatic inject(logic [7:0] v, bit e);
      @(negedge clk);
      rstn = 1'b1;
      en = e;
      clr = 1'b0;
      inj_v = v;
      force dut0.state_q = inj_v;
      force dut1.state_q = inj_v;
      #1;
      release dut0.state_q;
      release dut1.state_q;
      ms[0] = v;
      ms[1] = v;
      step_all(e, 1'b0);
   endtask

   task automatic arst();
      snap4_t a;
      snap4_t e;
      @(negedge clk);
      en = 1'b0;
      clr = 1'b0;
      #2 rstn = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) m_reset(k);
      a = act();
      e = mk_exp();
      for (int k = 0; k < 4; k++) chk(k, "async_rst", a[k], e[k]);
      sb.push_back(e);
   endtask

   initial begin : monitor
      snap4_t a;
      snap4_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            a = act();
            for (int k = 0; k < 4; k++) chk(k, "mon", a[k], e[k]);
         end
      end
   end

   initial begin : stim
      rstn = 1'b0;
      en = 1'b0;
      clr = 1'b0;
      inj_v = '0;
      for (int k = 0; k < 4; k++) m_reset(k);
      sb.push_back(mk_exp());
      repeat (5) cyc(1'b0, 1'b0);
      repeat (12) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      inject(8'h07, 1'b0);
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      for (int n = 0; n < 300; n++) begin
         if (n == 150) begin
            arst();
         end else if ($urandom_range(0, 24) == 0) begin
            inject(8'($urandom), $urandom_range(0, 1) == 1);
         end else begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
         end
      end
      for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d snapshots left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
